// File: rtl/dot_product_engine_if.sv
// Scratchpad port bundle for the dot-product engine:
// per-lane read addresses/data plus per-lane write port.
interface dot_product_engine_if #(
  parameter int LANES  = 4,
  parameter int ADDR_W = 6,
  parameter int W      = 16
);
  logic [LANES-1:0][ADDR_W-1:0] mem_raddrA;
  logic [LANES-1:0][ADDR_W-1:0] mem_raddrB;
  logic [LANES-1:0][W-1:0]      mem_rdataA;
  logic [LANES-1:0][W-1:0]      mem_rdataB;
  logic [LANES-1:0]             mem_wen;
  logic [LANES-1:0][ADDR_W-1:0] mem_waddr;
  logic [LANES-1:0][W-1:0]      mem_wdata;

  modport master (
    output mem_raddrA, mem_raddrB,
    input  mem_rdataA, mem_rdataB,
    output mem_wen, mem_waddr, mem_wdata
  );

  modport slave (
    input  mem_raddrA, mem_raddrB,
    output mem_rdataA, mem_rdataB,
    input  mem_wen, mem_waddr, mem_wdata
  );
endinterface

// File: rtl/dot_product_engine.sv
// Dot-product accelerator: streams LANES element pairs per beat
// from scratchpad regions A/B, reduces them, writes one scalar to C.
package GPU_Shader_pkg;
  localparam int lanes     = 4;
  localparam int MEM_DEPTH = 64;
  typedef logic [15:0] word_t;
endpackage

module dot_product_engine #(
  parameter int LANES     = GPU_Shader_pkg::lanes,
  parameter int MEM_DEPTH = GPU_Shader_pkg::MEM_DEPTH,
  parameter int W         = $bits(GPU_Shader_pkg::word_t)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] baseA,
  input  logic [31:0] baseB,
  input  logic [31:0] baseC,
  input  logic [31:0] length,
  output logic        busy,
  output logic        done,
  dot_product_engine_if.master mem
);
  localparam int ADDR_W = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_WRITE,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_baseA;
  logic [ADDR_W-1:0] r_baseB;
  logic [ADDR_W-1:0] r_baseC;
  logic [7:0]        r_len;
  logic [7:0]        r_k;
  logic [W-1:0]      r_acc;
  logic              r_busy;
  logic              r_done;

  logic [LANES-1:0][31:0] w_idx;
  logic [LANES-1:0]       w_act;
  logic [LANES-1:0][W-1:0] w_prod;
  logic [W-1:0]           w_sum;
  logic                   w_last;
  logic                   w_unused;

  assign w_unused = ^{baseA[31:ADDR_W], baseB[31:ADDR_W],
                      baseC[31:ADDR_W], length[31:8]};

  assign w_last = ((32'(r_k) + 32'd1) * 32'(LANES))
                  >= 32'(r_len);

  // Lanes past the tail of the vector read address 0 and add nothing
  always_comb begin
    w_sum = '0;
    mem.mem_raddrA = '0;
    mem.mem_raddrB = '0;
    for (int l = 0; l < LANES; l++) begin
      w_idx[l]  = 32'(r_k) * 32'(LANES) + 32'(l);
      w_act[l]  = (r_state == S_RUN) &&
                  (w_idx[l] < 32'(r_len));
      w_prod[l] = '0;
      if (w_act[l]) begin
        mem.mem_raddrA[l] = r_baseA + w_idx[l][ADDR_W-1:0];
        mem.mem_raddrB[l] = r_baseB + w_idx[l][ADDR_W-1:0];
        w_prod[l] = mem.mem_rdataA[l] * mem.mem_rdataB[l];
      end
      w_sum = w_sum + w_prod[l];
    end
  end

  always_comb begin
    mem.mem_wen   = '0;
    mem.mem_waddr = '0;
    mem.mem_wdata = '0;
    if (r_state == S_WRITE) begin
      mem.mem_wen[0]   = 1'b1;
      mem.mem_waddr[0] = r_baseC;
      mem.mem_wdata[0] = r_acc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_baseA <= '0;
      r_baseB <= '0;
      r_baseC <= '0;
      r_len   <= '0;
      r_k     <= '0;
      r_acc   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_baseA <= baseA[ADDR_W-1:0];
            r_baseB <= baseB[ADDR_W-1:0];
            r_baseC <= baseC[ADDR_W-1:0];
            r_len   <= length[7:0];
            r_k     <= '0;
            r_acc   <= '0;
            r_busy  <= 1'b1;
            r_state <= (length[7:0] != 8'd0) ? S_RUN
                                             : S_WRITE;
          end
        end
        S_RUN: begin
          r_acc <= r_acc + w_sum;
          if (w_last) begin
            r_state <= S_WRITE;
          end else begin
            r_k <= r_k + 8'd1;
          end
        end
        S_WRITE: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
endmodule
